// File: rtl/tx_block.sv
// UART transmitter: one-entry holding buffer feeding a start/data/stop serializer.
// Frame size and bit period are latched per frame so mid-frame config changes are harmless.
module tx_block (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  data_size,
    input  logic [13:0] bit_period,
    input  logic [7:0]  tx_data,
    input  logic        data_write,
    output logic        buffer_full,
    output logic        tx_busy,
    output logic        frame_done,
    output logic        write_error,
    input  logic        clear_error,
    output logic        serial_out
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  hold_reg;
    logic [7:0]  shift_reg;
    logic [7:0]  shift_next;
    logic [13:0] bit_timer;
    logic [13:0] timer_next;
    logic [13:0] frame_period;
    logic [3:0]  frame_size;
    logic [2:0]  bit_idx;
    logic [2:0]  idx_next;
    logic [3:0]  eff_size;
    logic [13:0] eff_period;
    logic        serial_next;
    logic        bit_end;
    logic        last_bit;
    logic        transfer;
    logic        write_accept;
    logic        write_drop;

    // Clamp the requested configuration to the supported range before latching it.
    always_comb begin
        eff_size   = data_size;
        eff_period = bit_period;
        if (data_size < 4'd5) begin
            eff_size = 4'd5;
        end else if (data_size > 4'd8) begin
            eff_size = 4'd8;
        end
        if (bit_period < 14'd2) begin
            eff_period = 14'd2;
        end
    end

    assign bit_end      = (state != IDLE) && (bit_timer == frame_period - 14'd1);
    assign last_bit     = ({1'b0, bit_idx} == frame_size - 4'd1);
    assign transfer     = buffer_full && ((state == IDLE) || ((state == STOP) && bit_end));
    assign write_accept = data_write && (!buffer_full || transfer);
    assign write_drop   = data_write && buffer_full && !transfer;

    assign tx_busy    = (state != IDLE);
    assign frame_done = (state == STOP) && bit_end;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
        state_next  = state;
        shift_next  = shift_reg;
        timer_next  = bit_timer;
        idx_next    = bit_idx;
        serial_next = 1'b1;

        if (state != IDLE) begin
            timer_next = bit_end ? 14'd0 : bit_timer + 14'd1;
        end

        case (state)
            IDLE: begin
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    idx_next   = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (last_bit) begin
                        state_next = STOP;
                    end else begin
                        idx_next = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_next = IDLE;
                end
            end
        endcase

        // A transfer overrides the normal STOP exit, giving back-to-back frames.
        if (transfer) begin
            state_next = START;
            shift_next = hold_reg;
            timer_next = 14'd0;
            idx_next   = 3'd0;
        end

        // The line is registered, so it is driven from the state being entered.
        case (state_next)
            IDLE:    serial_next = 1'b1;
            START:   serial_next = 1'b0;
            DATA:    serial_next = shift_next[0];
            STOP:    serial_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values.
        if (rst) begin
            state        <= IDLE;
            hold_reg     <= 8'd0;
            shift_reg    <= 8'd0;
            bit_timer    <= 14'd0;
            bit_idx      <= 3'd0;
            frame_size   <= 4'd0;
            frame_period <= 14'd0;
            buffer_full  <= 1'b0;
            write_error  <= 1'b0;
            serial_out   <= 1'b1;
        end else begin
            state      <= state_next;
            shift_reg  <= shift_next;
            bit_timer  <= timer_next;
            bit_idx    <= idx_next;
            serial_out <= serial_next;

            if (transfer) begin
                frame_size   <= eff_size;
                frame_period <= eff_period;
            end

            if (write_accept) begin
                hold_reg    <= tx_data;
                buffer_full <= 1'b1;
            end else if (transfer) begin
                buffer_full <= 1'b0;
            end

            // A dropped write on the same edge as a clear keeps the flag set.
            if (write_drop) begin
                write_error <= 1'b1;
            end else if (clear_error) begin
                write_error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tx_block.sv
// Randomized and directed bench for tx_block against a per-cycle expected-line model.
// The model expands each frame into its bit-by-bit waveform and replays it cycle by cycle.
module tb_tx_block;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  data_size;
    logic [13:0] bit_period;
    logic [7:0]  tx_data;
    logic        data_write;
    logic        buffer_full;
    logic        tx_busy;
    logic        frame_done;
    logic        write_error;
    logic        clear_error;
    logic        serial_out;

    always #5 clk = ~clk;

    tx_block dut (
        .clk         (clk),
        .rst         (rst),
        .data_size   (data_size),
        .bit_period  (bit_period),
        .tx_data     (tx_data),
        .data_write  (data_write),
        .buffer_full (buffer_full),
        .tx_busy     (tx_busy),
        .frame_done  (frame_done),
        .write_error (write_error),
        .clear_error (clear_error),
        .serial_out  (serial_out)
    );

    typedef struct {
        logic val;
        logic last;
    } slot_t;

    // Expected line level for each remaining cycle of the frame in flight.
    slot_t      line_q[$];
    logic       m_hold_valid;
    logic [7:0] m_hold;
    logic       m_err;
    logic       m_was_full;
    logic       m_xfer;
    logic       chk_en = 1'b0;
    int         n_vec  = 0;
    int         n_err  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic void push_frame(input logic [7:0] b, input logic [3:0] ds,
                                       input logic [13:0] bp);
        int   sz;
        int   p;
        logic bits[$];
        slot_t s;
        sz = (ds < 5) ? 5 : ((ds > 8) ? 8 : int'(ds));
        p  = (bp < 2) ? 2 : int'(bp);
        bits.push_back(1'b0);
        for (int i = 0; i < sz; i++) bits.push_back(b[i]);
        bits.push_back(1'b1);
        for (int j = 0; j < bits.size(); j++) begin
            for (int k = 0; k < p; k++) begin
                s.val  = bits[j];
                s.last = (j == bits.size() - 1) && (k == p - 1);
                line_q.push_back(s);
            end
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            line_q.delete();
            m_hold_valid = 1'b0;
            m_hold       = 8'd0;
            m_err        = 1'b0;
        end else begin
            m_was_full = m_hold_valid;
            if (line_q.size() > 0) void'(line_q.pop_front());
            m_xfer = m_was_full && (line_q.size() == 0);
            if (m_xfer) begin
                push_frame(m_hold, data_size, bit_period);
                m_hold_valid = 1'b0;
            end
            if (data_write && (!m_was_full || m_xfer)) begin
                m_hold       = tx_data;
                m_hold_valid = 1'b1;
            end
            if (data_write && m_was_full && !m_xfer) m_err = 1'b1;
            else if (clear_error) m_err = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("serial_out", {31'd0, serial_out}, (line_q.size() > 0) ? {31'd0, line_q[0].val} : 32'd1);
            check("frame_done", {31'd0, frame_done}, (line_q.size() > 0) ? {31'd0, line_q[0].last} : 32'd0);
            check("tx_busy", {31'd0, tx_busy}, (line_q.size() > 0) ? 32'd1 : 32'd0);
            check("buffer_full", {31'd0, buffer_full}, {31'd0, m_hold_valid});
            check("write_error", {31'd0, write_error}, {31'd0, m_err});
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] b);
        data_write = 1'b1;
        tx_data    = b;
        @(negedge clk);
        data_write = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (frame_done !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("done_wait", {31'd0, frame_done}, 32'd1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst         = 1'b1;
        data_size   = 4'd8;
        bit_period  = 14'd10;
        tx_data     = 8'd0;
        data_write  = 1'b0;
        clear_error = 1'b0;
        idle(2);
        chk_en = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(2);

        // 8N1 at 10 clocks per bit; frame_done lands 100 edges after the transfer.
        wr(8'hA5);
        cnt = 1;
        while (frame_done !== 1'b1 && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        check("latency_a5", cnt, 101);
        idle(20);

        // Short frames and size clamping.
        data_size = 4'd5; bit_period = 14'd4;
        wr(8'hFF); idle(40);
        data_size = 4'd3;
        wr(8'h1A); idle(60);
        data_size = 4'd12;
        wr(8'hC3); idle(60);

        // Queued write, dropped write, then clear.
        data_size = 4'd8; bit_period = 14'd10;
        wr(8'h55); idle(5);
        wr(8'h0F); idle(5);
        wr(8'h33); idle(3);
        clear_error = 1'b1;
        @(negedge clk);
        clear_error = 1'b0;

        // Write landing on the STOP-exit transfer edge with the buffer full.
        wait_done();
        idle(2);
        wr(8'h77);
        wait_done();
        wr(8'h99);
        check("wr_on_xfer_full", {31'd0, buffer_full}, 32'd1);
        check("wr_on_xfer_err", {31'd0, write_error}, 32'd0);
        idle(300);

        // Reset in the middle of the data bits.
        wr(8'h3C); idle(40);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_line", {31'd0, serial_out}, 32'd1);
        check("rst_busy", {31'd0, tx_busy}, 32'd0);
        check("rst_full", {31'd0, buffer_full}, 32'd0);
        wr(8'hE7); idle(120);

        // Period change mid-frame only affects the next frame; period 1 clamps to 2.
        wr(8'hAB); idle(30);
        bit_period = 14'd20;
        wr(8'hCD); idle(320);
        bit_period = 14'd1;
        wr(8'h5A); idle(40);

        // Randomized traffic with occasional resets and error clears.
        for (int i = 0; i < 4000; i++) begin
            rst         = ($urandom_range(0, 799) == 0);
            data_write  = ($urandom_range(0, 19) == 0);
            tx_data     = 8'($urandom);
            clear_error = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 49) == 0) begin
                data_size  = 4'($urandom);
                bit_period = 14'($urandom_range(0, 6));
            end
            @(negedge clk);
        end
        rst         = 1'b0;
        data_write  = 1'b0;
        clear_error = 1'b0;
        idle(200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tx_block.md
Name: tx_block

Overview:
UART transmitter that pairs with the receive path. It accepts a parallel byte into a one-entry holding buffer and serializes it as one frame: start bit (0), data_size data bits LSB-first, then one stop bit (1). Data size and bit period are programmable and use the same encoding as the receive side, so a looped-back line round-trips data. It sits between the host write interface and the serial line output.

Parameters:
None. All configuration is through ports.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
data_size  input  4  data bits per frame; legal values 5..8
bit_period  input  14  clock cycles per serial bit
tx_data  input  8  byte to transmit; only bits [data_size-1:0] are sent
data_write  input  1  strobe; when accepted, captures tx_data into the holding buffer
buffer_full  output  1  holding buffer occupied
tx_busy  output  1  frame in progress (state != IDLE)
frame_done  output  1  one-cycle pulse at the end of each stop bit
write_error  output  1  sticky flag: a write was dropped because the buffer was full
clear_error  input  1  clears write_error
serial_out  output  1  serial line, registered, idles high

Behaviour:
- Reset (rst=1 sampled at a rising edge):
  - serial_out=1, buffer_full=0, tx_busy=0, frame_done=0, write_error=0.
  - State=IDLE; all counters and the shift register are 0.
  - Reset mid-frame aborts immediately; the line returns high after that edge.
- Holding buffer:
  - A write is accepted when data_write=1 and either buffer_full=0 or a transfer occurs on the same edge.
  - An accepted write captures tx_data and sets buffer_full.
  - A write while full with no transfer on that edge is dropped, the buffer is unchanged, and write_error is set.
  - If clear_error and a dropped write occur on the same edge, the set wins.
- Transfer:
  - A transfer occurs on an edge where the FSM is in IDLE with buffer_full=1, or at the end of STOP with buffer_full=1.
  - On transfer: buffer to shift register, buffer_full cleared (unless refilled on the same edge), data_size and bit_period latched for the frame.
  - Changes to data_size or bit_period mid-frame have no effect until the next frame.
- Configuration clamping at latch time:
  - Effective size = 5 if data_size<5; 8 if data_size>8.
  - Effective period = 2 if bit_period<2.
- FSM states and transitions:
  - IDLE: serial_out=1. Go to START on transfer.
  - START: serial_out=0 for period cycles, then go to DATA.
  - DATA: serial_out = shift_reg[0]. Each bit is held for period cycles, then the register shifts right. After size bits, go to STOP.
  - STOP: serial_out=1 for period cycles. At the last cycle: frame_done=1 for one cycle. Then go to START if buffer_full (back-to-back, zero idle cycles between the stop bit and the next start bit), else go to IDLE.
- Bit timer: counts 0..period-1 and wraps. The bit index counts 0..size-1.
- Latency:
  - A write at edge N into an idle, empty block transfers at edge N+1; serial_out falls after edge N+1.
  - Every bit lasts exactly period clocks.
  - Frame length = (size+2)*period clocks.
- tx_busy is 1 from the transfer edge through the last STOP cycle. It stays 1 across back-to-back frames.

Test Plan:
1. Reset, then data_size=8, bit_period=10, write 0xA5 -> serial_out low 10 clks, then bits 1,0,1,0,0,1,0,1 (10 clks each), high 10 clks; frame_done pulses at clk 100 after transfer; buffer_full clears one edge after the write.
2. data_size=5, bit_period=4, write 0xFF -> 5 data bits of 1 sent (frame 28 clks), upper bits ignored; data_size=3 behaves as 5, data_size=12 behaves as 8.
3. Write 0x55, then write 0x0F during the frame (accepted, buffer_full=1), then a third write while full -> write_error=1 and the third byte is dropped; the second frame's start bit begins the cycle after the first stop bit; assert clear_error -> write_error=0.
4. data_write on the exact edge of the transfer out of STOP with the buffer full -> accepted, buffer_full stays 1, no write_error.
5. Assert rst mid-DATA -> next cycle serial_out=1, tx_busy=0, buffer_full=0; a following write produces a clean full frame.
6. Change bit_period 10->20 mid-frame -> current frame keeps 10-clk bits and the next frame uses 20; bit_period=1 gives 2-clk bits; loopback into the receive path with matching settings -> received rx_data equals the sent byte, framing_error=0.
